// File: rtl/mem_access_unit.sv
// MEM-stage sequencer: decodes the EX/MEM bundle and runs scalar (1 beat) or vector (8 beat)
// load/store transactions on a req/ack port. Optional MEM_TIMEOUT_EN adds a per-beat ack timeout.
module mem_access_unit #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite_i,
    input  logic              VRegWrite_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              VMem_i,
    input  logic              MemtoReg_i,
    input  logic [31:0]       alu_result_i,
    input  logic [4:0]        write_addr_i,
    input  logic [31:0]       write_data_i,
    input  logic [31:0]       vdata_v0_i,
    input  logic [31:0]       vdata_v1_i,
    input  logic [31:0]       vdata_v2_i,
    input  logic [31:0]       vdata_v3_i,
    input  logic [31:0]       vdata_v4_i,
    input  logic [31:0]       vdata_v5_i,
    input  logic [31:0]       vdata_v6_i,
    input  logic [31:0]       vdata_v7_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i,
`ifdef MEM_TIMEOUT_EN
    output logic              mem_err_o,
`endif
    output logic              stall_o,
    output logic              RegWrite_o,
    output logic              VRegWrite_o,
    output logic [4:0]        write_addr_o,
    output logic [31:0]       wb_data_o,
    output logic [31:0]       vdata_v0_o,
    output logic [31:0]       vdata_v1_o,
    output logic [31:0]       vdata_v2_o,
    output logic [31:0]       vdata_v3_o,
    output logic [31:0]       vdata_v4_o,
    output logic [31:0]       vdata_v5_o,
    output logic [31:0]       vdata_v6_o,
    output logic [31:0]       vdata_v7_o
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        beat_q, beat_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              is_store_q, is_store_d;
    logic              is_vec_q, is_vec_d;
    logic              memtoreg_q, memtoreg_d;
    logic              rw_cap_q, rw_cap_d;
    logic              vrw_cap_q, vrw_cap_d;
    logic [4:0]        waddr_cap_q, waddr_cap_d;
    logic [31:0]       alu_cap_q, alu_cap_d;
    logic [31:0]       wdata_cap_q, wdata_cap_d;
    logic              rw_out_q, rw_out_d;
    logic              vrw_out_q, vrw_out_d;
    logic [4:0]        waddr_out_q, waddr_out_d;
    logic [31:0]       wb_out_q, wb_out_d;
    logic [31:0]       lane_q [8];
    logic [31:0]       lane_d [8];
    logic [31:0]       vout_q [8];
    logic [31:0]       vout_d [8];
    logic [31:0]       vdata_in [8];
    logic              is_mem;
    logic              in_access;

`ifdef MEM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
    assign mem_err_o = err_q;
`endif

    assign vdata_in[0] = vdata_v0_i;
    assign vdata_in[1] = vdata_v1_i;
    assign vdata_in[2] = vdata_v2_i;
    assign vdata_in[3] = vdata_v3_i;
    assign vdata_in[4] = vdata_v4_i;
    assign vdata_in[5] = vdata_v5_i;
    assign vdata_in[6] = vdata_v6_i;
    assign vdata_in[7] = vdata_v7_i;

    // MemRead is active-low; a simultaneous read+write request is handled as a store.
    assign is_mem    = !MemRead_i || MemWrite_i;
    assign in_access = (state_q == ACCESS);

    assign stall_o     = in_access || ((state_q == IDLE) && is_mem);
    assign mem_req_o   = in_access;
    assign mem_we_o    = in_access && is_store_q;
    assign mem_addr_o  = in_access ? (base_q + ADDR_W'(beat_q)) : '0;
    assign mem_wdata_o = in_access ? (is_vec_q ? lane_q[beat_q] : wdata_cap_q) : '0;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        base_d      = base_q;
        is_store_d  = is_store_q;
        is_vec_d    = is_vec_q;
        memtoreg_d  = memtoreg_q;
        rw_cap_d    = rw_cap_q;
        vrw_cap_d   = vrw_cap_q;
        waddr_cap_d = waddr_cap_q;
        alu_cap_d   = alu_cap_q;
        wdata_cap_d = wdata_cap_q;
        lane_d      = lane_q;
        rw_out_d    = 1'b0;
        vrw_out_d   = 1'b0;
        waddr_out_d = waddr_out_q;
        wb_out_d    = wb_out_q;
        vout_d      = vout_q;
`ifdef MEM_TIMEOUT_EN
        wait_d      = wait_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (is_mem) begin
                    state_d     = ACCESS;
                    beat_d      = 3'd0;
                    base_d      = alu_result_i[ADDR_W-1:0];
                    is_store_d  = MemWrite_i;
                    is_vec_d    = VMem_i;
                    memtoreg_d  = MemtoReg_i;
                    rw_cap_d    = RegWrite_i;
                    vrw_cap_d   = VRegWrite_i;
                    waddr_cap_d = write_addr_i;
                    alu_cap_d   = alu_result_i;
                    wdata_cap_d = write_data_i;
                    lane_d      = vdata_in;
`ifdef MEM_TIMEOUT_EN
                    wait_d      = '0;
`endif
                end else begin
                    rw_out_d    = RegWrite_i;
                    vrw_out_d   = VRegWrite_i;
                    waddr_out_d = write_addr_i;
                    wb_out_d    = alu_result_i;
                end
            end
            ACCESS: begin
                if (mem_ack_i) begin
                    if (!is_store_q) begin
                        lane_d[beat_q] = mem_rdata_i;
                    end
                    beat_d = beat_q + 3'd1;
`ifdef MEM_TIMEOUT_EN
                    wait_d = '0;
`endif
                    if (!is_vec_q || (beat_q == 3'd7)) begin
                        // lane_d already holds the final beat's read data
                        state_d     = DONE;
                        beat_d      = 3'd0;
                        rw_out_d    = rw_cap_q;
                        vrw_out_d   = vrw_cap_q;
                        waddr_out_d = waddr_cap_q;
                        wb_out_d    = memtoreg_q ? lane_d[0] : alu_cap_q;
                        vout_d      = lane_d;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    beat_d  = 3'd0;
                    wait_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= 3'd0;
            base_q      <= '0;
            is_store_q  <= 1'b0;
            is_vec_q    <= 1'b0;
            memtoreg_q  <= 1'b0;
            rw_cap_q    <= 1'b0;
            vrw_cap_q   <= 1'b0;
            waddr_cap_q <= '0;
            alu_cap_q   <= '0;
            wdata_cap_q <= '0;
            rw_out_q    <= 1'b0;
            vrw_out_q   <= 1'b0;
            waddr_out_q <= '0;
            wb_out_q    <= '0;
`ifdef MEM_TIMEOUT_EN
            wait_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            base_q      <= base_d;
            is_store_q  <= is_store_d;
            is_vec_q    <= is_vec_d;
            memtoreg_q  <= memtoreg_d;
            rw_cap_q    <= rw_cap_d;
            vrw_cap_q   <= vrw_cap_d;
            waddr_cap_q <= waddr_cap_d;
            alu_cap_q   <= alu_cap_d;
            wdata_cap_q <= wdata_cap_d;
            rw_out_q    <= rw_out_d;
            vrw_out_q   <= vrw_out_d;
            waddr_out_q <= waddr_out_d;
            wb_out_q    <= wb_out_d;
`ifdef MEM_TIMEOUT_EN
            wait_q      <= wait_d;
            err_q       <= err_d;
`endif
        end
    end

    genvar gi;
    for (gi = 0; gi < 8; gi++) begin : g_lane
        always_ff @(posedge clk) begin
            if (rst) begin
                lane_q[gi] <= '0;
                vout_q[gi] <= '0;
            end else begin
                lane_q[gi] <= lane_d[gi];
                vout_q[gi] <= vout_d[gi];
            end
        end
    end

    assign RegWrite_o   = rw_out_q;
    assign VRegWrite_o  = vrw_out_q;
    assign write_addr_o = waddr_out_q;
    assign wb_data_o    = wb_out_q;
    assign vdata_v0_o   = vout_q[0];
    assign vdata_v1_o   = vout_q[1];
    assign vdata_v2_o   = vout_q[2];
    assign vdata_v3_o   = vout_q[3];
    assign vdata_v4_o   = vout_q[4];
    assign vdata_v5_o   = vout_q[5];
    assign vdata_v6_o   = vout_q[6];
    assign vdata_v7_o   = vout_q[7];
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table with a scoreboard queue plus
// hand-written reset-abort and (with MEM_TIMEOUT_EN) timeout sequences.
`timescale 1ns/1ps
module tb_mem_access_unit;
`ifdef MEM_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic        clk;
    logic        rst;
    logic        RegWrite_i, VRegWrite_i, MemRead_i, MemWrite_i, VMem_i, MemtoReg_i;
    logic [31:0] alu_result_i, write_data_i;
    logic [4:0]  write_addr_i;
    logic [31:0] vin [8];
    logic        mem_req_o, mem_we_o, mem_ack_i;
    logic [15:0] mem_addr_o;
    logic [31:0] mem_wdata_o, mem_rdata_i;
    logic        stall_o, RegWrite_o, VRegWrite_o;
    logic [4:0]  write_addr_o;
    logic [31:0] wb_data_o;
    logic [31:0] vout [8];
`ifdef MEM_TIMEOUT_EN
    logic        mem_err_o;
`endif

    mem_access_unit #(.ADDR_W(16), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .RegWrite_i(RegWrite_i), .VRegWrite_i(VRegWrite_i), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .VMem_i(VMem_i), .MemtoReg_i(MemtoReg_i),
        .alu_result_i(alu_result_i), .write_addr_i(write_addr_i), .write_data_i(write_data_i),
        .vdata_v0_i(vin[0]), .vdata_v1_i(vin[1]), .vdata_v2_i(vin[2]), .vdata_v3_i(vin[3]),
        .vdata_v4_i(vin[4]), .vdata_v5_i(vin[5]), .vdata_v6_i(vin[6]), .vdata_v7_i(vin[7]),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
`ifdef MEM_TIMEOUT_EN
        .mem_err_o(mem_err_o),
`endif
        .stall_o(stall_o), .RegWrite_o(RegWrite_o), .VRegWrite_o(VRegWrite_o),
        .write_addr_o(write_addr_o), .wb_data_o(wb_data_o),
        .vdata_v0_o(vout[0]), .vdata_v1_o(vout[1]), .vdata_v2_o(vout[2]), .vdata_v3_o(vout[3]),
        .vdata_v4_o(vout[4]), .vdata_v5_o(vout[5]), .vdata_v6_o(vout[6]), .vdata_v7_o(vout[7])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd_n, wr, vec, m2r, rw, vrw;
        logic [4:0]  waddr;
        logic [31:0] alu, wdata, lbase;
        int          k;
        logic [31:0] rbase;
        logic        e_rw, e_vrw;
        logic [31:0] e_wb;
        int          e_stall, e_beats;
        logic        chk_lanes;
        logic [31:0] e_vbase;
    } txn_t;

    txn_t        tbl [10];
    txn_t        sb [$];
    int          checks = 0;
    int          errors = 0;

    // memory responder state
    int          ack_k = 0;
    logic [31:0] rbase = 0;
    int          wcnt = 0;
    int          beat_seen = 0;
    logic [15:0] log_addr [8];
    logic        log_we [8];
    logic [31:0] log_wdata [8];

    // Ack after ack_k wait cycles per beat; read data is rbase + beat index.
    always @(negedge clk) begin
        if (mem_req_o && !rst) begin
            if (wcnt == ack_k) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = rbase + 32'(beat_seen);
                if (beat_seen < 8) begin
                    log_addr[beat_seen]  = mem_addr_o;
                    log_we[beat_seen]    = mem_we_o;
                    log_wdata[beat_seen] = mem_wdata_o;
                end
                beat_seen = beat_seen + 1;
                wcnt      = 0;
            end else begin
                mem_ack_i = 1'b0;
                wcnt      = wcnt + 1;
            end
        end else begin
            mem_ack_i = 1'b0;
            wcnt      = 0;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic txn_t mk(input logic rd_n, wr, vec, m2r, rw, vrw, input logic [4:0] waddr,
                                input logic [31:0] alu, wdata, lbase, input int k,
                                input logic [31:0] rb, input logic e_rw, e_vrw,
                                input logic [31:0] e_wb, input int e_stall, e_beats,
                                input logic chk_lanes, input logic [31:0] e_vbase);
        txn_t t;
        t.rd_n = rd_n; t.wr = wr; t.vec = vec; t.m2r = m2r; t.rw = rw; t.vrw = vrw;
        t.waddr = waddr; t.alu = alu; t.wdata = wdata; t.lbase = lbase; t.k = k; t.rbase = rb;
        t.e_rw = e_rw; t.e_vrw = e_vrw; t.e_wb = e_wb; t.e_stall = e_stall;
        t.e_beats = e_beats; t.chk_lanes = chk_lanes; t.e_vbase = e_vbase;
        return t;
    endfunction

    task automatic apply(input txn_t t);
        MemRead_i = t.rd_n; MemWrite_i = t.wr; VMem_i = t.vec; MemtoReg_i = t.m2r;
        RegWrite_i = t.rw; VRegWrite_i = t.vrw; write_addr_i = t.waddr;
        alu_result_i = t.alu; write_data_i = t.wdata;
        for (int n = 0; n < 8; n++) vin[n] = t.lbase + 32'(n);
    endtask

    task automatic apply_nop();
        MemRead_i = 1'b1; MemWrite_i = 1'b0; VMem_i = 1'b0; MemtoReg_i = 1'b0;
        RegWrite_i = 1'b0; VRegWrite_i = 1'b0; write_addr_i = '0;
        alu_result_i = '0; write_data_i = '0;
        for (int n = 0; n < 8; n++) vin[n] = '0;
    endtask

    task automatic run_txn(input int idx, input txn_t t);
        int   stall_cnt;
        bit   ok;
        txn_t e;
        @(posedge clk); #1;
        apply(t);
        ack_k = t.k; rbase = t.rbase; beat_seen = 0;
        sb.push_back(t);
        @(negedge clk);
        stall_cnt = int'(stall_o);
        @(posedge clk); #1;
        apply_nop();
        if (!t.rd_n || t.wr) begin
            ok = 1'b0;
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                if (stall_o) stall_cnt++;
                else begin
                    ok = 1'b1;
                    break;
                end
            end
            check("done_reached", 32'(ok), 32'd1);
            check("req_low_in_done", 32'(mem_req_o), 32'd0);
        end else begin
            @(negedge clk);
        end
        e = sb.pop_front();
        check("stall_cycles", stall_cnt, e.e_stall);
        check("regwrite", 32'(RegWrite_o), 32'(e.e_rw));
        check("vregwrite", 32'(VRegWrite_o), 32'(e.e_vrw));
        if (e.e_rw || e.e_vrw) check("write_addr", 32'(write_addr_o), 32'(e.waddr));
        if (e.e_rw) check("wb_data", wb_data_o, e.e_wb);
        check("beats", beat_seen, e.e_beats);
        for (int b = 0; b < e.e_beats && b < 8; b++) begin
            check("beat_addr", 32'(log_addr[b]), 32'(16'(e.alu[15:0] + 16'(b))));
            check("beat_we", 32'(log_we[b]), 32'(e.wr));
            if (e.wr) check("beat_wdata", log_wdata[b], e.vec ? e.lbase + 32'(b) : e.wdata);
        end
        if (e.chk_lanes)
            for (int n = 0; n < 8; n++) check("vlane", vout[n], e.e_vbase + 32'(n));
        $display("txn %0d stall=%0d beats=%0d rw=%0b vrw=%0b wb=%h", idx, stall_cnt,
                 beat_seen, RegWrite_o, VRegWrite_o, wb_data_o);
        @(negedge clk);
        check("rw_one_cycle", 32'(RegWrite_o), 32'd0);
        check("vrw_one_cycle", 32'(VRegWrite_o), 32'd0);
    endtask

    initial begin
        int  cnt;
        bit  ok;
        // rd_n wr vec m2r rw vrw waddr alu wdata lbase k rbase | e_rw e_vrw e_wb stall beats lanes vbase
        tbl[0] = mk(1,0,0,0,1,0,5'd3, 32'h55,       0,            0,     0, 0,            1,0,32'h55,       0, 0,0,0);
        tbl[1] = mk(0,0,0,1,1,0,5'd5, 32'h10,       0,            0,     2, 32'hDEADBEEF, 1,0,32'hDEADBEEF, 4, 1,0,0);
        tbl[2] = mk(1,1,1,0,0,0,5'd0, 32'hFFFC,     0,            0,     0, 0,            0,0,0,            9, 8,0,0);
        tbl[3] = mk(0,0,1,0,0,1,5'd7, 32'h20,       0,            0,     0, 32'h100,      0,1,0,            9, 8,1,32'h100);
        tbl[4] = mk(0,0,1,0,0,1,5'd9, 32'h40,       0,            0,     1, 32'h200,      0,1,0,            17,8,1,32'h200);
        tbl[5] = mk(0,0,0,0,1,0,5'd6, 32'h1234,     0,            0,     0, 32'hAAAA5555, 1,0,32'h1234,     2, 1,0,0);
        tbl[6] = mk(1,1,0,0,0,0,5'd0, 32'h30,       32'hCAFEF00D, 0,     1, 0,            0,0,0,            3, 1,0,0);
        tbl[7] = mk(0,1,0,0,0,0,5'd0, 32'h31,       32'h12345678, 0,     0, 0,            0,0,0,            2, 1,0,0);
        tbl[8] = mk(1,0,0,0,0,1,5'd10,32'h77,       0,            0,     0, 0,            0,1,0,            0, 0,0,0);
        tbl[9] = mk(1,1,1,0,0,0,5'd0, 32'h1234FFFE, 0,            32'hA0,2, 0,            0,0,0,            25,8,0,0);

        rst = 1'b1; mem_ack_i = 1'b0; mem_rdata_i = '0;
        apply_nop();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_rw", 32'(RegWrite_o), 32'd0);
        check("rst_vrw", 32'(VRegWrite_o), 32'd0);
        check("rst_wb", wb_data_o, 32'd0);
        check("rst_v0", vout[0], 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
`ifdef MEM_TIMEOUT_EN
        check("rst_err", 32'(mem_err_o), 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_txn(i, tbl[i]);

        // Reset in the middle of a vector load, while beat 3 is pending.
        @(posedge clk); #1;
        apply(tbl[3]);
        ack_k = 0; rbase = 32'h300; beat_seen = 0;
        @(posedge clk); #1;
        apply_nop();
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (beat_seen >= 3) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("abort_reach_beat3", 32'(ok), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_req", 32'(mem_req_o), 32'd0);
        check("abort_stall", 32'(stall_o), 32'd0);
        check("abort_v0", vout[0], 32'd0);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (VRegWrite_o || RegWrite_o || mem_req_o) cnt++;
        end
        check("abort_no_wb", cnt, 0);
        $display("txn abort beats_before_rst=%0d activity_after=%0d", beat_seen, cnt);

`ifdef MEM_TIMEOUT_EN
        // Scalar load that never receives an ack.
        @(posedge clk); #1;
        apply(tbl[1]);
        ack_k = 1000; beat_seen = 0;
        @(negedge clk);
        cnt = int'(stall_o);
        @(posedge clk); #1;
        apply_nop();
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (stall_o) cnt++;
            else begin
                ok = 1'b1;
                break;
            end
        end
        check("to_done", 32'(ok), 32'd1);
        check("to_stall", cnt, 5);
        check("to_rw", 32'(RegWrite_o), 32'd0);
        check("to_err", 32'(mem_err_o), 32'd1);
        repeat (3) @(negedge clk);
        check("to_err_sticky", 32'(mem_err_o), 32'd1);
        $display("txn timeout stall=%0d err=%0b", cnt, mem_err_o);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("to_err_clr", 32'(mem_err_o), 32'd0);
        ack_k = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
